// File: rtl/hazard_fwd_pkg.sv
// Shared types and constants for the decode-stage hazard and forwarding control.
// Tag entries mirror the destination/latency of each in-flight producer.
package hazard_fwd_pkg;

  localparam int TW = 2;
  localparam int SW = 3;

  localparam logic [SW-1:0] FWD_SEL_RF = '0;

  typedef enum int {
    STG_E = 0,
    STG_M = 1,
    STG_W = 2
  } stg_e;

  typedef struct packed {
    logic          valid;
    logic [4:0]    dst;
    logic [TW-1:0] tnew;
  } tag_t;

  function automatic logic [TW-1:0] tnew_dec(
    input logic [TW-1:0] t
  );
    return (t == '0) ? t : t - 1'b1;
  endfunction

endpackage

// File: rtl/fwd_port_sel.sv
// One decode read port: find the youngest producer of the source register
// and choose between forwarding, register file, or a stall.
module fwd_port_sel
  import hazard_fwd_pkg::*;
#(
  parameter int NUM_STG = 3,
  parameter int DW      = 32
) (
  input  logic [4:0]           addr,
  input  logic [TW-1:0]        tuse,
  input  tag_t [NUM_STG-1:0]   tags,
  input  logic [DW-1:0]        rf_rdata,
  input  logic [NUM_STG*DW-1:0] stg_data,
  output logic [SW-1:0]        sel,
  output logic [DW-1:0]        data,
  output logic                 stall
);

  logic hit;

  // Lowest index wins, so older producers of the same register are ignored.
  always_comb begin
    hit   = 1'b0;
    sel   = FWD_SEL_RF;
    data  = rf_rdata;
    stall = 1'b0;
    if (addr != 5'd0) begin
      for (int k = 0; k < NUM_STG; k++) begin
        if (!hit && tags[k].valid && tags[k].dst == addr) begin
          hit = 1'b1;
          if (tags[k].tnew == '0) begin
            sel  = SW'(k + 1);
            data = stg_data[k*DW +: DW];
          end else if (tags[k].tnew > tuse) begin
            stall = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard detection and operand forwarding for the decode stage.
// Define HAZARD_FWD_MD_BUSY_EN to build the mult/div busy counter.
module hazard_fwd_ctrl
  import hazard_fwd_pkg::*;
#(
  parameter int NUM_RP   = 2,
  parameter int NUM_STG  = 3,
  parameter int DW       = 32,
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   id_valid,
  input  logic [NUM_RP*5-1:0]    id_src_addr,
  input  logic [NUM_RP*TW-1:0]   id_src_tuse,
  input  logic [4:0]             id_dst_addr,
  input  logic [TW-1:0]          id_tnew,
  input  logic                   id_is_md,
  input  logic                   md_start,
  input  logic                   md_is_div,
  input  logic [NUM_RP*DW-1:0]   rf_rdata,
  input  logic [NUM_STG*DW-1:0]  stg_data,
  output logic [NUM_RP*SW-1:0]   fwd_sel,
  output logic [NUM_RP*DW-1:0]   fwd_data,
  output logic                   stall,
  output logic                   md_busy
);

  tag_t [NUM_STG-1:0] tags;
  logic [NUM_RP-1:0]  port_stall;
  logic               md_stall;
  logic               load;

  assign stall = (|port_stall) || md_stall;
  assign load  = id_valid && !stall && (id_dst_addr != 5'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tags <= '0;
    end else if (flush) begin
      tags <= '0;
    end else begin
      tags[STG_E] <= load ? tag_t'{1'b1, id_dst_addr, id_tnew} : '0;
      for (int k = 1; k < NUM_STG; k++) begin
        tags[k] <= tag_t'{tags[k-1].valid, tags[k-1].dst,
                          tnew_dec(tags[k-1].tnew)};
      end
    end
  end

  for (genvar p = 0; p < NUM_RP; p++) begin : g_port
    fwd_port_sel #(
      .NUM_STG(NUM_STG),
      .DW     (DW)
    ) u_sel (
      .addr    (id_src_addr[p*5 +: 5]),
      .tuse    (id_src_tuse[p*TW +: TW]),
      .tags    (tags),
      .rf_rdata(rf_rdata[p*DW +: DW]),
      .stg_data(stg_data),
      .sel     (fwd_sel[p*SW +: SW]),
      .data    (fwd_data[p*DW +: DW]),
      .stall   (port_stall[p])
    );
  end

`ifdef HAZARD_FWD_MD_BUSY_EN
  localparam int MAXC = (DIV_CYC > MULT_CYC) ? DIV_CYC : MULT_CYC;
  localparam int CW   = $clog2(MAXC + 1);

  logic [CW-1:0] md_cnt;

  // A start while the unit is still counting is dropped, not queued.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      md_cnt <= '0;
    end else if (md_cnt != '0) begin
      md_cnt <= md_cnt - 1'b1;
    end else if (md_start) begin
      md_cnt <= md_is_div ? CW'(DIV_CYC) : CW'(MULT_CYC);
    end
  end

  assign md_busy  = (md_cnt != '0) || md_start;
  assign md_stall = id_is_md && md_busy;
`else
  localparam int MD_CYC_UNUSED = MULT_CYC + DIV_CYC;
  logic md_in_unused;

  assign md_in_unused = id_is_md ^ md_start ^ md_is_div;
  assign md_busy      = 1'b0;
  assign md_stall     = 1'b0;
`endif

endmodule

// File: doc/hazard_fwd_ctrl.md
HAZARD_FWD_CTRL -- requirements
Module: hazard_fwd_ctrl

Interface
REQ-001 SHALL have parameter NUM_RP, default 2: number of decode-stage read ports.
REQ-002 SHALL have parameter NUM_STG, default 3: tracked producer stages after decode (0=E, 1=M, 2=W).
REQ-003 SHALL have parameter DW, default 32: data width.
REQ-004 SHALL have parameters MULT_CYC, default 5, and DIV_CYC, default 10: multiply/divide busy lengths.
REQ-005 SHALL have ports: clk  in  1  clock; reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have ports: flush  in  1  sync clear of all tracked entries; id_valid  in  1  decode holds a real instruction.
REQ-007 SHALL have ports: id_src_addr  in  NUM_RP*5  source register numbers; id_src_tuse  in  NUM_RP*2  cycles until each source is consumed.
REQ-008 SHALL have ports: id_dst_addr  in  5  destination register; id_tnew  in  2  cycles after E until the result exists.
REQ-009 SHALL have ports: id_is_md  in  1  decode instruction uses HI/LO; md_start  in  1  E starts mult/div; md_is_div  in  1  start is a divide.
REQ-010 SHALL have ports: rf_rdata  in  NUM_RP*DW  register file reads; stg_data  in  NUM_STG*DW  result of each stage.
REQ-011 SHALL have ports: fwd_sel  out  NUM_RP*3  per port, 0=RF, k+1=stage k; fwd_data  out  NUM_RP*DW  forwarded operand.
REQ-012 SHALL have ports: stall  out  1  freeze PC/D, bubble into E; md_busy  out  1  mult/div unit occupied.

Function
REQ-013 SHALL keep NUM_STG tag entries {valid, dst[4:0], tnew[1:0]}, entry k tracking stage k.
REQ-014 Each clock without flush: entry k+1 <= entry k with tnew saturating-decremented at 0; the last entry is discarded.
REQ-015 Entry 0 SHALL load {1, id_dst_addr, id_tnew} when id_valid && !stall && id_dst_addr!=0, otherwise valid=0 (bubble).
REQ-016 A port with address 0 SHALL select RF (fwd_sel=0) and never stall.
REQ-017 Match SHALL be the youngest (lowest k) valid entry with dst equal to the port address; older matches are ignored.
REQ-018 On a match with tnew==0: fwd_sel=k+1, fwd_data=stg_data[k]; with tnew>tuse: stall=1; with 0<tnew<=tuse: fwd_sel=0, no stall, resolved in a later stage.
REQ-019 With no match: fwd_sel=0, fwd_data=rf_rdata for that port.
REQ-020 stall SHALL be the OR over ports of REQ-018 stalls, the md stall (REQ-023), and nothing else; it is purely combinational on the current entries and inputs.
REQ-021 fwd_sel and fwd_data SHALL be combinational, with zero cycles from input change.
REQ-022 flush SHALL invalidate all entries at the next edge; flush dominates the entry 0 load; the md counter is unaffected.
REQ-023 md counter: md_start loads DIV_CYC if md_is_div, else MULT_CYC; it decrements to 0; md_busy = (count!=0) || md_start; stall asserts when id_is_md && md_busy.
REQ-024 md_start while count!=0 SHALL be ignored; the counter is not reloaded.

Reset
REQ-025 reset SHALL asynchronously clear all entries (valid=0, dst=0, tnew=0) and the md counter; outputs are then stall=0, md_busy=0, fwd_sel=0, fwd_data=rf_rdata.

Configuration
REQ-026 Macro HAZARD_FWD_MD_BUSY_EN defined: the md counter and REQ-023/024 are present.
REQ-027 Macro absent: no counter is built; md_busy is tied 0; id_is_md, md_start and md_is_div are ignored; the md stall term is 0.

Structure
REQ-028 Package hazard_fwd_pkg SHALL hold the tag-entry struct, the FWD_SEL_RF=0 constant, the stage index constants E/M/W, and the tnew/tuse width.
REQ-029 One sub-module, fwd_port_sel, SHALL be instantiated NUM_RP times and perform the per-port match, select and stall of REQ-016 to REQ-019.

Verification
REQ-030 Scenario: load E entry {$8, tnew=1}; decode reads $8 with tuse=0 -> stall=1 for 1 cycle, then fwd_sel=2 (M) and fwd_data=stg_data[1]=0x1234_5678.
REQ-031 Scenario: E entry {$9, tnew=0} and M entry {$9, tnew=0}, with stg_data E=0xAAAA_0001 and M=0xBBBB_0002 -> fwd_sel=1 and fwd_data=0xAAAA_0001.
REQ-032 Scenario: decode reads $0 while E entry has dst=0 forced -> fwd_sel=0, stall=0, fwd_data=rf_rdata=0.
REQ-033 Scenario: md_start with md_is_div=1, then id_is_md=1 -> md_busy=1 and stall=1 for 10 cycles, then both drop to 0; without the macro, stall stays 0.
REQ-034 Scenario: flush with id_valid=1 and dst=$3 -> all entries invalid next cycle, and a $3 read gives fwd_sel=0.
REQ-035 Scenario: reset asserted mid-divide (count=4) -> md_busy=0 and entries cleared immediately, without waiting for a clock edge.
